// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
//   Bundles every signal between the ALU arbiter and its surroundings: the
//   two requester ports (request + response slot), the shared ALU, and the
//   architectural flags.
//
//   Port 0 (main execute path)
//     req0_valid/ready, req0_ops[2:0], req0_src1[15:0], req0_src0[15:0],
//     req0_shamt[3:0], req0_flag_en; rsp0_valid/ready, rsp0_dst[15:0]
//   Port 1 (auxiliary unit)
//     same as port 0 without flag_en
//   ALU side
//     alu_ops/src1/src0/shamt out of the arbiter; alu_dst/ov/zr/n back in
//   Flags
//     flag_ov/zr/n driven by the arbiter
//
//   Modports: slave = the arbiter, master = the environment (requesters,
//   response consumers and the ALU itself).
// ----------------------------------------------------------------------------
interface alu_arbiter_if;

    // Port 0
    logic        req0_valid;
    logic        req0_ready;
    logic [2:0]  req0_ops;
    logic [15:0] req0_src1;
    logic [15:0] req0_src0;
    logic [3:0]  req0_shamt;
    logic        req0_flag_en;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [15:0] rsp0_dst;

    // Port 1
    logic        req1_valid;
    logic        req1_ready;
    logic [2:0]  req1_ops;
    logic [15:0] req1_src1;
    logic [15:0] req1_src0;
    logic [3:0]  req1_shamt;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [15:0] rsp1_dst;

    // Shared ALU
    logic [2:0]  alu_ops;
    logic [15:0] alu_src1;
    logic [15:0] alu_src0;
    logic [3:0]  alu_shamt;
    logic [15:0] alu_dst;
    logic        alu_ov;
    logic        alu_zr;
    logic        alu_n;

    // Architectural flags
    logic        flag_ov;
    logic        flag_zr;
    logic        flag_n;

    modport slave (
        input  req0_valid, req0_ops, req0_src1, req0_src0, req0_shamt, req0_flag_en,
        output req0_ready,
        output rsp0_valid, rsp0_dst,
        input  rsp0_ready,
        input  req1_valid, req1_ops, req1_src1, req1_src0, req1_shamt,
        output req1_ready,
        output rsp1_valid, rsp1_dst,
        input  rsp1_ready,
        output alu_ops, alu_src1, alu_src0, alu_shamt,
        input  alu_dst, alu_ov, alu_zr, alu_n,
        output flag_ov, flag_zr, flag_n
    );

    modport master (
        output req0_valid, req0_ops, req0_src1, req0_src0, req0_shamt, req0_flag_en,
        input  req0_ready,
        input  rsp0_valid, rsp0_dst,
        output rsp0_ready,
        output req1_valid, req1_ops, req1_src1, req1_src0, req1_shamt,
        input  req1_ready,
        input  rsp1_valid, rsp1_dst,
        output rsp1_ready,
        input  alu_ops, alu_src1, alu_src0, alu_shamt,
        output alu_dst, alu_ov, alu_zr, alu_n,
        input  flag_ov, flag_zr, flag_n
    );

endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one 16-bit combinational ALU between two requesters. One op is
//   granted per cycle, the granted port's operands are driven to the ALU in
//   the same cycle, and the ALU result is registered into that port's
//   single-entry response slot. Also owns the architectural flag register
//   (ov/zr/n), which only port-0 ops with flag_en may update.
//
// Parameters
//   PRIO_MODE  0 = round-robin between ports, 1 = fixed priority (port 0 wins)
//
// Ports
//   clk   clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   alu_arbiter_if.slave: request/response ports, ALU, flags
// ----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);

    localparam bit FixedPrio = (PRIO_MODE != 0);

    typedef enum logic [2:0] {
        OpAdd = 3'b000,
        OpSub = 3'b001,
        OpAnd = 3'b010,
        OpNor = 3'b011,
        OpSll = 3'b100,
        OpSrl = 3'b101,
        OpLhb = 3'b110,
        OpSra = 3'b111
    } alu_op_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic        last_grant_q, last_grant_d;  // 1 = port 1 was granted last
    logic        rsp0_valid_q, rsp0_valid_d;
    logic [15:0] rsp0_dst_q,   rsp0_dst_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic [15:0] rsp1_dst_q,   rsp1_dst_d;
    logic        flag_ov_q,    flag_ov_d;
    logic        flag_zr_q,    flag_zr_d;
    logic        flag_n_q,     flag_n_d;

    // ------------------------------------------------------------------------
    // Eligibility and grant
    // ------------------------------------------------------------------------
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;

    // A port may issue only if its slot is free or is being drained this
    // cycle, so each port has at most one result outstanding.
    assign elig0 = bus.req0_valid & (~rsp0_valid_q | bus.rsp0_ready);
    assign elig1 = bus.req1_valid & (~rsp1_valid_q | bus.rsp1_ready);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        // Nothing is accepted while reset is asserted.
        if (!rst) begin
            if (elig0 && elig1) begin
                // Round-robin: the port that was not granted last wins the tie.
                if (FixedPrio || last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = elig0;
                grant1 = elig1;
            end
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;

    // ------------------------------------------------------------------------
    // ALU operand mux; idle ALU inputs are forced to zero
    // ------------------------------------------------------------------------
    always_comb begin
        bus.alu_ops   = 3'b000;
        bus.alu_src1  = 16'h0000;
        bus.alu_src0  = 16'h0000;
        bus.alu_shamt = 4'h0;
        if (grant0) begin
            bus.alu_ops   = bus.req0_ops;
            bus.alu_src1  = bus.req0_src1;
            bus.alu_src0  = bus.req0_src0;
            bus.alu_shamt = bus.req0_shamt;
        end else if (grant1) begin
            bus.alu_ops   = bus.req1_ops;
            bus.alu_src1  = bus.req1_src1;
            bus.alu_src0  = bus.req1_src0;
            bus.alu_shamt = bus.req1_shamt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: grant history and response slots
    // ------------------------------------------------------------------------
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant0) begin
            last_grant_d = 1'b0;
        end else if (grant1) begin
            last_grant_d = 1'b1;
        end
    end

    // A grant always (re)loads the slot, which covers the drain-and-reload
    // case and keeps one op per cycle per port sustainable.
    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_dst_d   = rsp0_dst_q;
        if (grant0) begin
            rsp0_valid_d = 1'b1;
            rsp0_dst_d   = bus.alu_dst;
        end else if (rsp0_valid_q && bus.rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
    end

    always_comb begin
        rsp1_valid_d = rsp1_valid_q;
        rsp1_dst_d   = rsp1_dst_q;
        if (grant1) begin
            rsp1_valid_d = 1'b1;
            rsp1_dst_d   = bus.alu_dst;
        end else if (rsp1_valid_q && bus.rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state: architectural flags (port 0 only)
    // ------------------------------------------------------------------------
    always_comb begin
        flag_ov_d = flag_ov_q;
        flag_zr_d = flag_zr_q;
        flag_n_d  = flag_n_q;
        if (grant0 && bus.req0_flag_en) begin
            unique case (alu_op_e'(bus.req0_ops))
                OpAdd, OpSub: begin
                    flag_ov_d = bus.alu_ov;
                    flag_zr_d = bus.alu_zr;
                    flag_n_d  = bus.alu_n;
                end
                OpAnd, OpNor, OpSll, OpSrl, OpSra: begin
                    flag_zr_d = bus.alu_zr;
                end
                OpLhb: begin
                    // Load-high-byte never affects the flags.
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;  // port 0 wins the first round-robin tie
            rsp0_valid_q <= 1'b0;
            rsp0_dst_q   <= 16'h0000;
            rsp1_valid_q <= 1'b0;
            rsp1_dst_q   <= 16'h0000;
            flag_ov_q    <= 1'b0;
            flag_zr_q    <= 1'b0;
            flag_n_q     <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp0_dst_q   <= rsp0_dst_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp1_dst_q   <= rsp1_dst_d;
            flag_ov_q    <= flag_ov_d;
            flag_zr_q    <= flag_zr_d;
            flag_n_q     <= flag_n_d;
        end
    end

    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp0_dst   = rsp0_dst_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp1_dst   = rsp1_dst_q;
    assign bus.flag_ov    = flag_ov_q;
    assign bus.flag_zr    = flag_zr_q;
    assign bus.flag_n     = flag_n_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//   Directed bench for alu_arbiter. Two instances: a round-robin one (bus)
//   carrying most scenarios and a fixed-priority one (pbus) for the priority
//   check. Each has a small saturating ALU model attached on the ALU side.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    alu_arbiter_if bus ();
    alu_arbiter_if pbus ();

    alu_arbiter #(.PRIO_MODE(0)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_arbiter #(.PRIO_MODE(1)) u_dut_prio (
        .clk (clk),
        .rst (rst),
        .bus (pbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Saturating 16-bit ALU: returns {ov, zr, n, dst}; sub is src1 - src0,
    // lhb is {src0[7:0], src1[7:0]}.
    function automatic logic [18:0] alu_model(input logic [2:0] ops, input logic [15:0] a,
                                              input logic [15:0] b, input logic [3:0] sh);
        logic [15:0] d;
        logic        ov;
        ov = 1'b0;
        case (ops)
            3'b000: begin d = a + b; ov = (a[15] == b[15]) && (d[15] != a[15]); end
            3'b001: begin d = a - b; ov = (a[15] != b[15]) && (d[15] != a[15]); end
            3'b010: d = a & b;
            3'b011: d = ~(a | b);
            3'b100: d = a << sh;
            3'b101: d = a >> sh;
            3'b110: d = {b[7:0], a[7:0]};
            default: d = 16'($signed(a) >>> sh);
        endcase
        if (ov) d = a[15] ? 16'h8000 : 16'h7FFF;
        return {ov, (d == 16'h0000), d[15], d};
    endfunction

    always_comb begin
        {bus.alu_ov, bus.alu_zr, bus.alu_n, bus.alu_dst} =
            alu_model(bus.alu_ops, bus.alu_src1, bus.alu_src0, bus.alu_shamt);
    end

    always_comb begin
        {pbus.alu_ov, pbus.alu_zr, pbus.alu_n, pbus.alu_dst} =
            alu_model(pbus.alu_ops, pbus.alu_src1, pbus.alu_src0, pbus.alu_shamt);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs change and registered outputs are sampled 1
    // time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        check_eq(tag, {29'd0, bus.flag_ov, bus.flag_zr, bus.flag_n}, {29'd0, exp});
    endtask

    // Issue one port-0 op with rsp0_ready held high; the result is visible
    // on return and is drained by the next cycle.
    task automatic issue0(input logic [2:0] ops, input logic [15:0] s1, input logic [15:0] s0,
                          input logic [3:0] sh, input logic fe);
        bus.req0_valid   = 1'b1;
        bus.req0_ops     = ops;
        bus.req0_src1    = s1;
        bus.req0_src0    = s0;
        bus.req0_shamt   = sh;
        bus.req0_flag_en = fe;
        bus.rsp0_ready   = 1'b1;
        #2;
        check_eq("issue0_ready", {31'd0, bus.req0_ready}, 32'd1);
        step();
        bus.req0_valid = 1'b0;
    endtask

    task automatic issue1(input logic [2:0] ops, input logic [15:0] s1, input logic [15:0] s0);
        bus.req1_valid = 1'b1;
        bus.req1_ops   = ops;
        bus.req1_src1  = s1;
        bus.req1_src0  = s0;
        bus.req1_shamt = 4'h0;
        bus.rsp1_ready = 1'b1;
        #2;
        check_eq("issue1_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        {bus.req0_valid, bus.req0_ops, bus.req0_src1, bus.req0_src0, bus.req0_shamt,
         bus.req0_flag_en, bus.rsp0_ready} = '0;
        {bus.req1_valid, bus.req1_ops, bus.req1_src1, bus.req1_src0, bus.req1_shamt,
         bus.rsp1_ready} = '0;
        {pbus.req0_valid, pbus.req0_ops, pbus.req0_src1, pbus.req0_src0, pbus.req0_shamt,
         pbus.req0_flag_en, pbus.rsp0_ready} = '0;
        {pbus.req1_valid, pbus.req1_ops, pbus.req1_src1, pbus.req1_src0, pbus.req1_shamt,
         pbus.rsp1_ready} = '0;
        step();
        // A valid request during reset must not be accepted.
        bus.req0_valid = 1'b1;
        #2;
        check_eq("rst_no_grant", {31'd0, bus.req0_ready}, 32'd0);
        step();
        bus.req0_valid = 1'b0;
        rst = 1'b0;

        // Reset state
        check_eq("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
        check_eq("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
        check_eq("rst_rsp0_dst", {16'd0, bus.rsp0_dst}, 32'd0);
        check_flags("rst_flags", 3'b000);

        // Fixed priority: port 0 wins every cycle, port 1 starves
        pbus.req0_valid = 1'b1; pbus.req0_ops = 3'b000; pbus.req0_src1 = 16'd1;
        pbus.req1_valid = 1'b1; pbus.req1_ops = 3'b000; pbus.req1_src1 = 16'd2;
        pbus.rsp0_ready = 1'b1; pbus.rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("prio_g0", {31'd0, pbus.req0_ready}, 32'd1);
            check_eq("prio_g1", {31'd0, pbus.req1_ready}, 32'd0);
            step();
        end
        check_eq("prio_rsp1_empty", {31'd0, pbus.rsp1_valid}, 32'd0);
        pbus.req0_valid = 1'b0;
        pbus.req1_valid = 1'b0;

        // 1: port 0 add 3 + 4 with flags
        bus.req0_valid = 1'b1; bus.req0_ops = 3'b000; bus.req0_src1 = 16'h0003;
        bus.req0_src0 = 16'h0004; bus.req0_flag_en = 1'b1; bus.rsp0_ready = 1'b0;
        #2;
        check_eq("t1_ready", {31'd0, bus.req0_ready}, 32'd1);
        check_eq("t1_alu_src1", {16'd0, bus.alu_src1}, 32'h0003);
        step();
        bus.req0_valid = 1'b0;
        #2;
        check_eq("idle_alu_src1", {16'd0, bus.alu_src1}, 32'h0000);
        check_eq("t1_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check_eq("t1_rsp0_dst", {16'd0, bus.rsp0_dst}, 32'h0007);
        check_flags("t1_flags", 3'b000);
        bus.rsp0_ready = 1'b1;
        step();
        check_eq("t1_drained", {31'd0, bus.rsp0_valid}, 32'd0);

        // 2: saturating add, then sub reloading the slot while it drains
        issue0(3'b000, 16'h7FFF, 16'h0001, 4'h0, 1'b1);
        check_eq("t2_sat_dst", {16'd0, bus.rsp0_dst}, 32'h7FFF);
        check_flags("t2_sat_flags", 3'b100);
        issue0(3'b001, 16'h0005, 16'h0005, 4'h0, 1'b1);
        check_eq("t2_b2b_valid", {31'd0, bus.rsp0_valid}, 32'd1);
        check_eq("t2_sub_dst", {16'd0, bus.rsp0_dst}, 32'h0000);
        check_flags("t2_sub_flags", 3'b010);
        step();

        // 3: round-robin; port 0 was granted last, so port 1 goes first
        bus.req0_valid = 1'b1; bus.req0_ops = 3'b000; bus.req0_src1 = 16'd1;
        bus.req0_src0 = 16'd0; bus.req0_flag_en = 1'b0; bus.rsp0_ready = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_ops = 3'b000; bus.req1_src1 = 16'd2;
        bus.req1_src0 = 16'd0; bus.rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            check_eq("rr_g0", {31'd0, bus.req0_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check_eq("rr_g1", {31'd0, bus.req1_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check_eq("rr_alu_src1", {16'd0, bus.alu_src1}, (i % 2 == 0) ? 32'd2 : 32'd1);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        step();
        check_flags("rr_flags_hold", 3'b010);

        // 4: backpressure on port 1
        bus.rsp1_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_ops = 3'b010;
        bus.req1_src1 = 16'h00F0; bus.req1_src0 = 16'h0FF0;
        #2;
        check_eq("t4_first_ready", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_ops = 3'b000; bus.req1_src1 = 16'h0001; bus.req1_src0 = 16'h0002;
        #2;
        check_eq("t4_blocked", {31'd0, bus.req1_ready}, 32'd0);
        step();
        check_eq("t4_frozen_dst", {16'd0, bus.rsp1_dst}, 32'h00F0);
        check_eq("t4_frozen_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        bus.rsp1_ready = 1'b1;
        #2;
        check_eq("t4_unblocked", {31'd0, bus.req1_ready}, 32'd1);
        step();
        bus.req1_valid = 1'b0;
        check_eq("t4_reload_valid", {31'd0, bus.rsp1_valid}, 32'd1);
        check_eq("t4_reload_dst", {16'd0, bus.rsp1_dst}, 32'h0003);
        step();
        check_eq("t4_drained", {31'd0, bus.rsp1_valid}, 32'd0);

        // 5: flag update classes and port-1 isolation
        issue0(3'b000, 16'h7FFF, 16'h0001, 4'h0, 1'b1);
        check_flags("t5_ov_set", 3'b100);
        issue0(3'b011, 16'hFFFF, 16'h0000, 4'h0, 1'b1);
        check_flags("t5_nor_zr_only", 3'b110);
        issue0(3'b010, 16'hFFFF, 16'h8000, 4'h0, 1'b1);
        check_eq("t5_and_dst", {16'd0, bus.rsp0_dst}, 32'h8000);
        check_flags("t5_and_zr_only", 3'b100);
        issue1(3'b001, 16'h8000, 16'h0001);
        check_eq("t5_p1_sat_dst", {16'd0, bus.rsp1_dst}, 32'h8000);
        check_flags("t5_p1_no_flags", 3'b100);
        issue0(3'b110, 16'h1200, 16'h0000, 4'h0, 1'b1);
        check_eq("t5_lhb_dst", {16'd0, bus.rsp0_dst}, 32'h0000);
        check_flags("t5_lhb_no_flags", 3'b100);
        issue0(3'b111, 16'h8000, 16'h0000, 4'h3, 1'b0);
        check_eq("t5_sra_dst", {16'd0, bus.rsp0_dst}, 32'hF000);
        step();

        // 6: reset with both slots full
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_ops = 3'b000; bus.req0_src1 = 16'h0011;
        bus.req0_src0 = 16'h0000; bus.req0_flag_en = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_ops = 3'b000; bus.req1_src1 = 16'h0022;
        bus.req1_src0 = 16'h0000;
        step();
        step();
        bus.req1_valid = 1'b0;
        check_eq("t6_full0", {31'd0, bus.rsp0_valid}, 32'd1);
        check_eq("t6_full1", {31'd0, bus.rsp1_valid}, 32'd1);
        rst = 1'b1;
        bus.rsp0_ready = 1'b1;
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        check_eq("t6_rsp0_cleared", {31'd0, bus.rsp0_valid}, 32'd0);
        check_eq("t6_rsp1_cleared", {31'd0, bus.rsp1_valid}, 32'd0);
        check_eq("t6_dst1_cleared", {16'd0, bus.rsp1_dst}, 32'd0);
        check_flags("t6_flags_cleared", 3'b000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
